wb_rr_arbiter: RTL and testbench

- Shares one downstream Wishbone master port, feeding the conbus master 0 slot, between NUM_MASTERS requesters.
- Typical requesters are the Raspberry SPI bridge, the MCU bridge and a future DMA.
- Arbitration is round-robin with per-cycle bus locking while the granted master holds cyc.
- A watchdog terminates cycles that get no ack from a slave and reports an error to the owning master.

---
 rtl/wb_rr_arbiter_if.sv | 52 +++++
 rtl/wb_rr_arbiter.sv | 263 ++++++++++++++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_rr_arbiter_if.sv
// Wishbone bus bundle used by wb_rr_arbiter.
//
// Upstream side (NUM_MASTERS requesters, packed per master k at [k*W +: W]):
//   m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i  requests in
//   m_dat_o   read data, broadcast to every master
//   m_ack_o   per-master ack
//   m_err_o   per-master watchdog error
// Downstream side (one Wishbone master port into the conbus):
//   s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o  muxed request out
//   s_dat_i, s_ack_i  slave response
//
// Modports:
//   slave  - view taken by the arbiter (it is the slave of the requesters)
//   master - view taken by whatever drives the requests and models the slave
interface wb_rr_arbiter_if #(
  parameter int NUM_MASTERS = 3,
  parameter int ADDR_WIDTH  = 14,
  parameter int DATA_WIDTH  = 16
);
  logic [NUM_MASTERS-1:0]            m_cyc_i;
  logic [NUM_MASTERS-1:0]            m_stb_i;
  logic [NUM_MASTERS-1:0]            m_we_i;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i;
  logic [NUM_MASTERS*2-1:0]          m_sel_i;
  logic [DATA_WIDTH-1:0]             m_dat_o;
  logic [NUM_MASTERS-1:0]            m_ack_o;
  logic [NUM_MASTERS-1:0]            m_err_o;

  logic                              s_cyc_o;
  logic                              s_stb_o;
  logic                              s_we_o;
  logic [ADDR_WIDTH-1:0]             s_adr_o;
  logic [DATA_WIDTH-1:0]             s_dat_o;
  logic [1:0]                        s_sel_o;
  logic [DATA_WIDTH-1:0]             s_dat_i;
  logic                              s_ack_i;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
    output m_dat_o, m_ack_o, m_err_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
    input  s_dat_i, s_ack_i
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
    input  m_dat_o, m_ack_o, m_err_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
    output s_dat_i, s_ack_i
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter - round-robin arbiter sharing one downstream Wishbone master
// port (conbus master 0 slot) between NUM_MASTERS requesters.
//
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset
//   bus      wb_rr_arbiter_if.slave: upstream requests and downstream port
//   grant_o  one-hot current owner, zero when idle
//   busy_o   high while a master owns the bus
//
// Behaviour: a master is granted one cycle after raising cyc and keeps the
// bus for as long as it holds cyc (locked multi-beat cycles). When it lets go
// the arbiter spends one idle cycle, then searches again starting at the
// master after the previous owner.
//
// Build option: define WB_ARB_TIMEOUT_EN to include the no-ack watchdog and
// the one-cycle ERR state that reports m_err_o to the stalled owner. Without
// it m_err_o is tied low and an owner waits for ack indefinitely.

// Per-master request gating: a master's request only reaches the downstream
// OR-tree while it holds the grant.
module wb_rr_arbiter_lane #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  gnt,
  input  logic                  cyc,
  input  logic                  stb,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] adr,
  input  logic [DATA_WIDTH-1:0] dat,
  input  logic [1:0]            sel,
  output logic                  cyc_o,
  output logic                  stb_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] adr_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic [1:0]            sel_o
);
  assign cyc_o = gnt & cyc;
  // stb without cyc is meaningless; drop it so the watchdog never counts it
  assign stb_o = gnt & cyc & stb;
  assign we_o  = gnt & we;
  assign adr_o = gnt ? adr : '0;
  assign dat_o = gnt ? dat : '0;
  assign sel_o = gnt ? sel : '0;
endmodule

module wb_rr_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int ADDR_WIDTH  = 14,
  parameter int DATA_WIDTH  = 16,
  parameter int TIMEOUT     = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  wb_rr_arbiter_if.slave         bus,
  output logic [NUM_MASTERS-1:0] grant_o,
  output logic                   busy_o
);
  localparam int PW = $clog2(NUM_MASTERS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN  = 2'd1;
`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [1:0] S_ERR  = 2'd2;
`endif

  if (NUM_MASTERS < 2 || NUM_MASTERS > 4) begin : g_bad_nm
    $error("wb_rr_arbiter: NUM_MASTERS must be 2..4");
  end
  if (TIMEOUT < 1 || TIMEOUT > 1023) begin : g_bad_to
    $error("wb_rr_arbiter: TIMEOUT must be 1..1023");
  end

  // (p + inc) mod NUM_MASTERS; explicit wrap since NUM_MASTERS need not be 2^n
  function automatic logic [PW-1:0] add_mod(input logic [PW-1:0] p, input int inc);
    int s;
    s = int'(p) + inc;
    if (s >= NUM_MASTERS) s = s - NUM_MASTERS;
    return s[PW-1:0];
  endfunction

  logic [1:0]             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [PW-1:0]          ptr_q, ptr_d;
`ifdef WB_ARB_TIMEOUT_EN
  logic [9:0]             cnt_q, cnt_d;
  logic [NUM_MASTERS-1:0] err_q, err_d;
`endif

  // ---------------- per-master lanes ----------------
  logic [NUM_MASTERS-1:0]                 l_cyc, l_stb, l_we;
  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] l_adr;
  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] l_dat;
  logic [NUM_MASTERS-1:0][1:0]            l_sel;

  for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_lane
    wb_rr_arbiter_lane #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_lane (
      .gnt   (grant_q[k]),
      .cyc   (bus.m_cyc_i[k]),
      .stb   (bus.m_stb_i[k]),
      .we    (bus.m_we_i[k]),
      .adr   (bus.m_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH]),
      .dat   (bus.m_dat_i[k*DATA_WIDTH +: DATA_WIDTH]),
      .sel   (bus.m_sel_i[k*2 +: 2]),
      .cyc_o (l_cyc[k]),
      .stb_o (l_stb[k]),
      .we_o  (l_we[k]),
      .adr_o (l_adr[k]),
      .dat_o (l_dat[k]),
      .sel_o (l_sel[k])
    );
  end

  // grant is one-hot (or zero), so OR-reducing the gated lanes is the mux
  logic                  cyc_any, stb_any, we_any;
  logic [ADDR_WIDTH-1:0] adr_any;
  logic [DATA_WIDTH-1:0] dat_any;
  logic [1:0]            sel_any;

  always_comb begin
    cyc_any = 1'b0;
    stb_any = 1'b0;
    we_any  = 1'b0;
    adr_any = '0;
    dat_any = '0;
    sel_any = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      cyc_any = cyc_any | l_cyc[k];
      stb_any = stb_any | l_stb[k];
      we_any  = we_any  | l_we[k];
      adr_any = adr_any | l_adr[k];
      dat_any = dat_any | l_dat[k];
      sel_any = sel_any | l_sel[k];
    end
  end

  logic own;
  logic s_stb;
  assign own   = (state_q == S_OWN);
  assign s_stb = own & stb_any;

  // ---------------- downstream / upstream outputs ----------------
  assign bus.s_cyc_o = own & cyc_any;
  assign bus.s_stb_o = s_stb;
  assign bus.s_we_o  = we_any;
  assign bus.s_adr_o = adr_any;
  assign bus.s_dat_o = dat_any;
  assign bus.s_sel_o = sel_any;
  assign bus.m_dat_o = bus.s_dat_i;
  assign bus.m_ack_o = own ? (grant_q & {NUM_MASTERS{bus.s_ack_i}}) : '0;
`ifdef WB_ARB_TIMEOUT_EN
  assign bus.m_err_o = err_q;
`else
  assign bus.m_err_o = '0;
`endif
  assign grant_o = grant_q;
  assign busy_o  = own;

  // ---------------- arbitration ----------------
  logic          found;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] cand;

  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      cand = add_mod(ptr_q, i);
      if (!found && bus.m_cyc_i[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  logic [PW-1:0] own_idx;
  logic          cyc_g;

  always_comb begin
    own_idx = '0;
    for (int k = 0; k < NUM_MASTERS; k++)
      if (grant_q[k]) own_idx = PW'(k);
  end

  assign cyc_g = |(grant_q & bus.m_cyc_i);

  // ---------------- FSM ----------------
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
`ifdef WB_ARB_TIMEOUT_EN
    cnt_d   = '0;
    err_d   = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d          = S_OWN;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
        end
      end
      S_OWN: begin
        if (!cyc_g) begin
          // an ack in this same cycle has already passed through combinationally
          state_d = S_IDLE;
          grant_d = '0;
          ptr_d   = add_mod(own_idx, 1);
        end
`ifdef WB_ARB_TIMEOUT_EN
        else if (s_stb && !bus.s_ack_i) begin
          // an ack on the final waiting cycle lands in the else path: no error
          if (cnt_q == 10'(TIMEOUT - 1)) begin
            state_d = S_ERR;
            err_d   = grant_q;
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end
`endif
      end
`ifdef WB_ARB_TIMEOUT_EN
      S_ERR: begin
        // grant is held through ERR so the owner index is still known here
        state_d = S_IDLE;
        grant_d = '0;
        ptr_d   = add_mod(own_idx, 1);
      end
`endif
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
`ifdef WB_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
`ifdef WB_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
module tb_wb_rr_arbiter;
  localparam int NM = 3;
  localparam int AW = 14;
  localparam int DW = 16;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NM-1:0] grant;
  logic          busy;

  int n_vec = 0;
  int n_err = 0;

  wb_rr_arbiter_if #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  wb_rr_arbiter #(
    .NUM_MASTERS (NM),
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .TIMEOUT     (TO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .grant_o (grant),
    .busy_o  (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    bus.m_cyc_i = '0;
    bus.m_stb_i = '0;
    bus.m_we_i  = '0;
    bus.m_adr_i = '0;
    bus.m_dat_i = '0;
    bus.m_sel_i = '0;
    bus.s_dat_i = '0;
    bus.s_ack_i = 1'b0;
  endtask

  task automatic req(input int k, input logic on);
    bus.m_cyc_i[k] = on;
    bus.m_stb_i[k] = on;
  endtask

  task automatic do_reset();
    clr();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  logic [NM-1:0] exp_g;
  int            order [4] = '{0, 1, 2, 0};

  initial begin
    clr();
    // ---------------- reset state ----------------
    @(negedge clk);
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_scyc", bus.s_cyc_o, 0);
    chk("rst_ack", bus.m_ack_o, 0);
    chk("rst_err", bus.m_err_o, 0);
    do_reset();

    // ---------------- single request, master 1 ----------------
    req(1, 1'b1);
    bus.m_we_i[1]           = 1'b1;
    bus.m_adr_i[1*AW +: AW] = 14'h2804;
    bus.m_dat_i[1*DW +: DW] = 16'h00A5;
    bus.m_sel_i[1*2 +: 2]   = 2'b11;
    #1 chk("single_lat0", grant, 0);
    @(negedge clk);                                  // cycle 1
    chk("single_gnt", grant, 3'b010);
    chk("single_busy", busy, 1);
    chk("single_adr", bus.s_adr_o, 14'h2804);
    chk("single_dat", bus.s_dat_o, 16'h00A5);
    chk("single_we", bus.s_we_o, 1);
    chk("single_cyc", bus.s_cyc_o, 1);
    chk("single_stb", bus.s_stb_o, 1);
    chk("single_sel", bus.s_sel_o, 2'b11);
    @(negedge clk);                                  // cycle 2
    chk("single_noack", bus.m_ack_o, 0);
    @(negedge clk);                                  // cycle 3
    bus.s_ack_i = 1'b1;
    bus.s_dat_i = 16'h1234;
    #1 chk("single_ack", bus.m_ack_o, 3'b010);
    chk("single_rdat", bus.m_dat_o, 16'h1234);
    @(negedge clk);
    bus.s_ack_i = 1'b0;
    req(1, 1'b0);
    @(negedge clk);
    chk("single_release", grant, 0);
    // pointer now 2: masters 0 and 2 both request, 2 must win
    req(0, 1'b1);
    req(2, 1'b1);
    @(negedge clk);
    chk("single_ptr2", grant, 3'b100);
    req(2, 1'b0);
    @(negedge clk);
    chk("single_gap", grant, 0);
    @(negedge clk);
    chk("single_wrap0", grant, 3'b001);
    clr();
    @(negedge clk);

    // ---------------- round robin ----------------
    do_reset();
    for (int k = 0; k < NM; k++) req(k, 1'b1);
    #1 chk("rr_idle0", grant, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp_g = NM'(1) << order[i];
      chk("rr_gnt", grant, exp_g);
      bus.s_ack_i = 1'b1;
      req(order[i], 1'b0);                           // drop cyc with the ack
      #1 chk("rr_ack", bus.m_ack_o, exp_g);
      @(negedge clk);
      bus.s_ack_i = 1'b0;
      chk("rr_gap", grant, 0);
      req(order[i], 1'b1);
    end
    clr();
    @(negedge clk);

    // ---------------- locked cycle ----------------
    do_reset();
    req(0, 1'b1);
    req(2, 1'b1);
    @(negedge clk);
    for (int b = 0; b < 4; b++) begin
      chk("lock_gnt", grant, 3'b001);
      bus.s_ack_i = 1'b1;
      #1 chk("lock_ack", bus.m_ack_o, 3'b001);
      @(negedge clk);
      bus.s_ack_i = 1'b0;
      #1 chk("lock_hold", grant, 3'b001);
      @(negedge clk);
    end
    req(0, 1'b0);
    @(negedge clk);
    chk("lock_gap", grant, 0);
    @(negedge clk);
    chk("lock_m2", grant, 3'b100);
    clr();
    @(negedge clk);

`ifdef WB_ARB_TIMEOUT_EN
    // ---------------- watchdog timeout ----------------
    do_reset();
    req(2, 1'b1);
    @(negedge clk);
    for (int i = 0; i < TO; i++) begin
      chk("to_stb", bus.s_stb_o, 1);
      chk("to_noerr", bus.m_err_o, 0);
      @(negedge clk);
    end
    chk("to_err", bus.m_err_o, 3'b100);
    chk("to_cyc", bus.s_cyc_o, 0);
    chk("to_stb_lo", bus.s_stb_o, 0);
    chk("to_busy", busy, 0);
    chk("to_ack", bus.m_ack_o, 0);
    req(2, 1'b0);
    @(negedge clk);
    chk("to_err1cyc", bus.m_err_o, 0);
    chk("to_idle", grant, 0);
    @(negedge clk);
`else
    // ---------------- no watchdog: owner waits ----------------
    do_reset();
    req(2, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 3 * TO; i++) begin
      chk("wait_gnt", grant, 3'b100);
      chk("wait_noerr", bus.m_err_o, 0);
      @(negedge clk);
    end
    clr();
    @(negedge clk);
`endif

    // ---------------- ack race on last waiting cycle ----------------
    do_reset();
    req(2, 1'b1);
    @(negedge clk);
    for (int i = 0; i < TO - 1; i++) begin
      chk("race_stb", bus.s_stb_o, 1);
      @(negedge clk);
    end
    bus.s_ack_i = 1'b1;
    #1 chk("race_ack", bus.m_ack_o, 3'b100);
    @(negedge clk);
    bus.s_ack_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("race_noerr", bus.m_err_o, 0);
      chk("race_gnt", grant, 3'b100);
      @(negedge clk);
    end
    clr();
    @(negedge clk);

    // ---------------- reset mid-cycle ----------------
    do_reset();
    req(1, 1'b1);
    @(negedge clk);
    chk("mid_own", bus.s_cyc_o, 1);
    #2 rst = 1'b1;
    bus.s_ack_i = 1'b1;
    #1 chk("mid_scyc", bus.s_cyc_o, 0);
    chk("mid_gnt", grant, 0);
    chk("mid_ack", bus.m_ack_o, 0);
    chk("mid_err", bus.m_err_o, 0);
    req(0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    bus.s_ack_i = 1'b0;
    @(negedge clk);
    chk("mid_m0first", grant, 3'b001);
    clr();
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation time limit");
  end
endmodule
